// File: rtl/icache_if.sv
// Fetcher, memory-controller, invalidate and flush signals of the instruction cache.
// slave is the cache side; master is the environment (fetcher, memory controller, ROB).
interface icache_if;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_inst;
    logic        out_mem_ce;
    logic [31:0] out_mem_addr;
    logic        in_mem_ce;
    logic [31:0] in_mem_data;
    logic        in_inv_ce;
    logic [31:0] in_inv_addr;
    logic        in_rob_misbranch;

    modport slave (
        input  in_fetcher_ce,
        input  in_fetcher_addr,
        output out_fetcher_ce,
        output out_fetcher_inst,
        output out_mem_ce,
        output out_mem_addr,
        input  in_mem_ce,
        input  in_mem_data,
        input  in_inv_ce,
        input  in_inv_addr,
        input  in_rob_misbranch
    );

    modport master (
        output in_fetcher_ce,
        output in_fetcher_addr,
        input  out_fetcher_ce,
        input  out_fetcher_inst,
        input  out_mem_ce,
        input  out_mem_addr,
        output in_mem_ce,
        output in_mem_data,
        output in_inv_ce,
        output in_inv_addr,
        output in_rob_misbranch
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-cycle hits,
// one outstanding memory read on a miss, misbranch flush and store invalidation.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int TAG_BITS = 16 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    // state    | meaning
    // IDLE     | accepting fetches; hits answered next cycle
    // WAIT_MEM | read issued to memory controller, waiting for in_mem_ce
    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t state_q, state_nxt;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic        fetch_ce_nxt;
    logic [31:0] fetch_inst_nxt;
    logic        mem_ce_nxt;
    logic [31:0] mem_addr_nxt;
    logic        fill_en;

    logic [INDEX_BITS-1:0] req_idx, fill_idx, inv_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag, inv_tag;
    logic                  req_cacheable, fill_cacheable, req_hit, inv_en;

    assign req_idx        = bus.in_fetcher_addr[INDEX_BITS+1:2];
    assign req_tag        = bus.in_fetcher_addr[17:INDEX_BITS+2];
    assign req_cacheable  = (bus.in_fetcher_addr[17:16] != 2'b11);
    assign req_hit        = req_cacheable && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The latched request address doubles as the fill address.
    assign fill_idx       = bus.out_mem_addr[INDEX_BITS+1:2];
    assign fill_tag       = bus.out_mem_addr[17:INDEX_BITS+2];
    assign fill_cacheable = (bus.out_mem_addr[17:16] != 2'b11);

    assign inv_idx        = bus.in_inv_addr[INDEX_BITS+1:2];
    assign inv_tag        = bus.in_inv_addr[17:INDEX_BITS+2];
    // A store landing on the index being filled this cycle must not leave stale data valid.
    assign inv_en         = bus.in_inv_ce &&
                            ((valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag)) ||
                             (fill_en && (fill_idx == inv_idx)));

    always_comb begin
        state_nxt      = state_q;
        fetch_ce_nxt   = 1'b0;
        fetch_inst_nxt = bus.out_fetcher_inst;
        mem_ce_nxt     = 1'b0;
        mem_addr_nxt   = bus.out_mem_addr;
        fill_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_fetcher_ce && !bus.in_rob_misbranch) begin
                    if (req_hit) begin
                        fetch_ce_nxt   = 1'b1;
                        fetch_inst_nxt = data_q[req_idx];
                    end else begin
                        mem_ce_nxt   = 1'b1;
                        mem_addr_nxt = bus.in_fetcher_addr;
                        state_nxt    = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.in_mem_ce) begin
                    fill_en   = fill_cacheable;
                    state_nxt = IDLE;
                    if (!bus.in_rob_misbranch) begin
                        fetch_ce_nxt   = 1'b1;
                        fetch_inst_nxt = bus.in_mem_data;
                    end
                end else if (bus.in_rob_misbranch) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= IDLE;
            bus.out_fetcher_ce   <= 1'b0;
            bus.out_fetcher_inst <= 32'h0;
            bus.out_mem_ce       <= 1'b0;
            bus.out_mem_addr     <= 32'h0;
        end else if (rdy) begin
            state_q              <= state_nxt;
            bus.out_fetcher_ce   <= fetch_ce_nxt;
            bus.out_fetcher_inst <= fetch_inst_nxt;
            bus.out_mem_ce       <= mem_ce_nxt;
            bus.out_mem_addr     <= mem_addr_nxt;
        end
    end

    // Invalidate is applied after the fill so it takes precedence on the same line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy) begin
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (inv_en) begin
                valid_q[inv_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.in_mem_data;
        end
    end
endmodule
